// File: rtl/baud_pkg.sv
// Shared definitions for the baud-rate sequencer.
//   - Register address map (2-bit index from the bus decode).
//   - CTRL register bit positions.
//   - Default divisor width.
package baud_pkg;

    localparam int DIV_WIDTH_DEF = 16;

    localparam logic [1:0] ADDR_DIV_LO = 2'd0;
    localparam logic [1:0] ADDR_DIV_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_HOLD_BIT = 1;

endpackage

// File: rtl/baud_phase_counter.sv
// 4-bit phase counter stepped by the 16x oversample enable.
// Ports:
//   clk, reset  - system clock, async active-high reset
//   tick        - advance enable (one clock wide)
//   clear       - synchronous clear, wins over tick
//   phase       - current phase value
//   strobe      - tick & (phase == MATCH), suppressed while clear is high
module baud_phase_counter #(
    parameter logic [3:0] MATCH = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear,
    output logic [3:0] phase,
    output logic       strobe
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 4'd0;
        end else if (clear) begin
            phase <= 4'd0;
        end else if (tick) begin
            phase <= phase + 4'd1;
        end
    end

    assign strobe = tick & ~clear & (phase == MATCH);

endmodule

// File: rtl/baud_controller.sv
// Programmable baud-rate sequencer for the UART path.
// A CPU-writable divisor drives a prescaler that emits a 16x oversample
// enable (tick16); two phase counters derive the TX bit strobe and the RX
// mid-bit sample strobe. A new divisor is staged in shadow_div and only
// committed at a prescaler reload (or at once while disabled).
// Ports:
//   clk, reset        - system clock, async active-high reset
//   cs, rw, addr      - bus select, 1=read/0=write, register index
//   data_in, data_out - write data, combinational read data
//   rx_start          - start-bit edge pulse, re-aligns the RX phase
//   tick16, tx_tick, rx_tick - one-clock strobes
//   baud_clk          - legacy square wave (tx_phase[3])
// Optional build macro: BAUD_FRAC_EN adds a 4-bit fractional divisor in
// CTRL[7:4]; undefined, those bits read 0 and ignore writes.
module baud_controller
    import baud_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int RESET_DIV = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       rx_start,
    output logic       tick16,
    output logic       tx_tick,
    output logic       rx_tick,
    output logic       baud_clk
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);

    logic [DIV_WIDTH-1:0] shadow_div;
    logic [DIV_WIDTH-1:0] active_div;
    logic [DIV_WIDTH-1:0] prescaler;
    logic [DIV_WIDTH-1:0] reload_base;
    logic [DIV_WIDTH-1:0] reload_val;
    logic [15:0]          shadow_view;
    logic                 enable;
    logic                 rx_hold;
    logic                 pending;
    logic                 wr_en;
    logic                 wr_div_hi;
    logic                 at_zero;
    logic [3:0]           tx_phase;
    logic [3:0]           rx_phase;
    logic                 tx_strobe;
    logic                 rx_strobe;
    logic [3:0]           frac_rd;

    assign wr_en       = cs & ~rw;
    assign wr_div_hi   = wr_en & (addr == ADDR_DIV_HI);
    assign at_zero     = (prescaler == '0);
    assign tick16      = enable & at_zero;
    assign shadow_view = 16'(shadow_div);

    // A pending divisor takes effect at the reload itself, not one period late.
    assign reload_base = pending ? shadow_div : active_div;

`ifdef BAUD_FRAC_EN
    logic [3:0] frac;
    logic [3:0] acc;
    logic [4:0] acc_sum;

    assign acc_sum    = {1'b0, acc} + {1'b0, frac};
    // Carry out of the accumulator stretches the next period by one clock.
    assign reload_val = reload_base + DIV_WIDTH'(acc_sum[4]);
    assign frac_rd    = frac;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frac <= 4'd0;
            acc  <= 4'd0;
        end else begin
            if (wr_en && addr == ADDR_CTRL) begin
                frac <= data_in[7:4];
            end
            if (tick16) begin
                acc <= acc_sum[3:0];
            end
        end
    end
`else
    assign reload_val = reload_base;
    assign frac_rd    = 4'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_div <= RST_DIV;
            enable     <= 1'b1;
            rx_hold    <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                ADDR_DIV_LO: shadow_div <= DIV_WIDTH'({shadow_view[15:8], data_in});
                ADDR_DIV_HI: shadow_div <= DIV_WIDTH'({data_in, shadow_view[7:0]});
                ADDR_CTRL: begin
                    enable  <= data_in[CTRL_EN_BIT];
                    rx_hold <= data_in[CTRL_HOLD_BIT];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_div <= RST_DIV;
            prescaler  <= RST_DIV;
            pending    <= 1'b0;
        end else begin
            if (!enable) begin
                if (pending) begin
                    active_div <= shadow_div;
                    prescaler  <= shadow_div;
                end
            end else if (at_zero) begin
                prescaler <= reload_val;
                if (pending) begin
                    active_div <= shadow_div;
                end
            end else begin
                prescaler <= prescaler - DIV_WIDTH'(1);
            end

            // A DIV_HI write racing a commit keeps pending set, so the freshly
            // written value still commits at the following reload.
            if (wr_div_hi) begin
                pending <= 1'b1;
            end else if (pending && (!enable || at_zero)) begin
                pending <= 1'b0;
            end
        end
    end

    baud_phase_counter #(.MATCH(4'd15)) u_tx_phase (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick16),
        .clear  (1'b0),
        .phase  (tx_phase),
        .strobe (tx_strobe)
    );

    baud_phase_counter #(.MATCH(4'd7)) u_rx_phase (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick16),
        .clear  (rx_start),
        .phase  (rx_phase),
        .strobe (rx_strobe)
    );

    assign tx_tick  = tx_strobe;
    assign rx_tick  = rx_strobe & ~rx_hold;
    assign baud_clk = tx_phase[3];

    always_comb begin
        data_out = 8'h00;
        if (cs && rw) begin
            case (addr)
                ADDR_DIV_LO: data_out = shadow_view[7:0];
                ADDR_DIV_HI: data_out = shadow_view[15:8];
                ADDR_CTRL: begin
                    data_out[7:4]          = frac_rd;
                    data_out[CTRL_EN_BIT]   = enable;
                    data_out[CTRL_HOLD_BIT] = rx_hold;
                end
                default: data_out = {tx_phase, 2'b00, pending, enable};
            endcase
        end
    end

endmodule

// File: tb/tb_baud_controller.sv
module tb_baud_controller;
    import baud_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rx_start;
    logic       tick16;
    logic       tx_tick;
    logic       rx_tick;
    logic       baud_clk;

    baud_controller dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rx_start (rx_start),
        .tick16   (tick16),
        .tx_tick  (tx_tick),
        .rx_tick  (rx_tick),
        .baud_clk (baud_clk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Scoreboard: expected gaps (in clocks) between successive strobes.
    int t16_q[$];
    int tx_q[$];
    bit t16_have = 0;
    bit tx_have  = 0;
    int t16_last;
    int tx_last;
    int mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (tick16 && t16_q.size() > 0) begin
                if (t16_have) begin
                    mon_e = t16_q.pop_front();
                    check("tick16_gap", cyc - t16_last, mon_e);
                end
                t16_have = 1;
                t16_last = cyc;
            end
            if (tx_tick && tx_q.size() > 0) begin
                if (tx_have) begin
                    mon_e = tx_q.pop_front();
                    check("tx_tick_gap", cyc - tx_last, mon_e);
                end
                tx_have = 1;
                tx_last = cyc;
            end
        end
    end

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return tick16;
            1:       return tx_tick;
            default: return rx_tick;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int budget, input string nm, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig_of(sel)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no strobe within %0d cycles", nm, budget);
            at = cyc;
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (t16_q.size() == 0 && tx_q.size() == 0) return;
            @(negedge clk);
        end
        check(nm, t16_q.size() + tx_q.size(), 0);
        t16_q.delete();
        tx_q.delete();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        cs      = 1'b1;
        rw      = 1'b0;
        addr    = a;
        data_in = d;
        @(negedge clk);
        cs = 1'b0;
        rw = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        cs   = 1'b1;
        rw   = 1'b1;
        addr = a;
        #1;
        d  = data_out;
        cs = 1'b0;
    endtask

    task automatic wait_commit(input int budget, input string nm);
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < budget; i++) begin
            bus_rd(ADDR_STATUS, d);
            if (!d[1]) break;
            @(negedge clk);
        end
        check(nm, int'(d[1]), 0);
    endtask

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
        logic       chk;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[16];

`ifdef BAUD_FRAC_EN
    localparam logic [7:0] CTRL_F3_RD  = 8'hF3;
    localparam logic [7:0] CTRL_81_RD  = 8'h81;
    localparam int         FRAC_TOTAL  = 72;
    localparam bit         FRAC_ON     = 1'b1;
`else
    localparam logic [7:0] CTRL_F3_RD  = 8'h03;
    localparam logic [7:0] CTRL_81_RD  = 8'h01;
    localparam int         FRAC_TOTAL  = 64;
    localparam bit         FRAC_ON     = 1'b0;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, t2, tl, r1, r2, r3, b_cyc, c_cyc, n_t, n_r;
        logic [7:0] d;

        vecs[0]  = '{1'b1, 1'b1, ADDR_DIV_LO, 8'h00, 1'b1, 8'h11};
        vecs[1]  = '{1'b1, 1'b1, ADDR_DIV_HI, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, ADDR_CTRL,   8'h00, 1'b1, 8'h01};
        vecs[3]  = '{1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b1, 8'h01};
        vecs[4]  = '{1'b1, 1'b0, ADDR_DIV_LO, 8'hA5, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, ADDR_DIV_LO, 8'h00, 1'b1, 8'hA5};
        vecs[6]  = '{1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b1, 8'h01};
        vecs[7]  = '{1'b1, 1'b0, ADDR_CTRL,   8'hF3, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, ADDR_CTRL,   8'h00, 1'b1, CTRL_F3_RD};
        vecs[9]  = '{1'b1, 1'b0, ADDR_STATUS, 8'hFF, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b1, 8'h01};
        vecs[11] = '{1'b1, 1'b0, ADDR_CTRL,   8'h01, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 1'b1, ADDR_CTRL,   8'h00, 1'b1, 8'h01};
        vecs[13] = '{1'b0, 1'b1, ADDR_DIV_LO, 8'h00, 1'b1, 8'h00};
        vecs[14] = '{1'b1, 1'b0, ADDR_DIV_LO, 8'h11, 1'b0, 8'h00};
        vecs[15] = '{1'b1, 1'b1, ADDR_DIV_HI, 8'h00, 1'b1, 8'h00};

        reset    = 1'b1;
        cs       = 1'b0;
        rw       = 1'b1;
        addr     = 2'd0;
        data_in  = 8'h00;
        rx_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tick16", int'(tick16), 0);
        check("rst_tx_tick", int'(tx_tick), 0);
        check("rst_rx_tick", int'(rx_tick), 0);
        check("rst_baud_clk", int'(baud_clk), 0);
        reset = 1'b0;

        // Reset asserted mid-count while tick16 is high.
        bus_wr(ADDR_DIV_LO, 8'h05);
        bus_wr(ADDR_DIV_HI, 8'h00);
        wait_sig(0, 40, "midrst_tick_a", t);
        wait_sig(0, 20, "midrst_tick_b", t);
        #1 reset = 1'b1;
        #1;
        check("midrst_tick16", int'(tick16), 0);
        check("midrst_tx_tick", int'(tx_tick), 0);
        check("midrst_baud_clk", int'(baud_clk), 0);
        @(negedge clk);
        reset = 1'b0;

        // Register map vectors.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cs      = vecs[i].cs;
            rw      = vecs[i].rw;
            addr    = vecs[i].addr;
            data_in = vecs[i].data;
            #1;
            if (vecs[i].chk) check($sformatf("reg_vec%0d", i), int'(data_out), int'(vecs[i].exp_d));
        end
        @(negedge clk);
        cs = 1'b0;
        rw = 1'b1;

        // Rate with DIV=3.
        bus_wr(ADDR_DIV_LO, 8'h03);
        bus_wr(ADDR_DIV_HI, 8'h00);
        bus_rd(ADDR_STATUS, d);
        check("rate_pending_set", int'(d[1:0]), 3);
        wait_sig(0, 40, "rate_commit_tick", t);
        bus_rd(ADDR_STATUS, d);
        check("rate_pending_at_reload", int'(d[1]), 1);
        @(negedge clk);
        bus_rd(ADDR_STATUS, d);
        check("rate_pending_cleared", int'(d[1]), 0);
        #1;
        t16_have = 0;
        tx_have  = 0;
        for (int i = 0; i < 16; i++) t16_q.push_back(4);
        tx_q.push_back(64);
        tx_q.push_back(64);
        wait_drain(300, "rate_drain");

        // RX alignment: rx_start in a tick16 cycle.
        wait_sig(0, 10, "rx_align_tick", t);
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
        wait_sig(2, 80, "rx_first", r1);
        check("rx_first_delay", r1 - t, 32);
        wait_sig(2, 100, "rx_second", r2);
        check("rx_period", r2 - r1, 64);

        // rx_start collides with tick16 while rx_phase == 7.
        while (cyc < r2 + 64) @(negedge clk);
        check("coll_tick16", int'(tick16), 1);
        rx_start = 1'b1;
        #1;
        check("coll_rx_suppressed", int'(rx_tick), 0);
        @(negedge clk);
        rx_start = 1'b0;
        wait_sig(2, 80, "coll_rx_next", r3);
        check("coll_rx_realign", r3 - (r2 + 64), 32);

        // rx_hold blocks rx_tick only.
        bus_wr(ADDR_CTRL, 8'h03);
        n_t = 0;
        n_r = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tick16) n_t++;
            if (rx_tick) n_r++;
        end
        check("hold_rx_ticks", n_r, 0);
        check("hold_tick16s", n_t, 20);
        bus_wr(ADDR_CTRL, 8'h01);

        // Disable with tx_phase parked at 5.
        wait_sig(1, 80, "dis_tx_align", t);
        for (int k = 0; k < 5; k++) wait_sig(0, 10, "dis_step", t);
        bus_wr(ADDR_CTRL, 8'h00);
        bus_rd(ADDR_STATUS, d);
        check("dis_status", int'(d), 8'h50);
        n_t = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick16 || tx_tick || rx_tick) n_t++;
        end
        check("dis_no_ticks", n_t, 0);
        bus_rd(ADDR_STATUS, d);
        check("dis_frozen_status", int'(d), 8'h50);
        bus_wr(ADDR_DIV_LO, 8'h07);
        bus_wr(ADDR_DIV_HI, 8'h00);
        bus_rd(ADDR_STATUS, d);
        check("dis_pending_set", int'(d), 8'h52);
        @(negedge clk);
        bus_rd(ADDR_STATUS, d);
        check("dis_pending_1clk", int'(d), 8'h50);
        @(negedge clk);
        c_cyc = cyc;
        bus_wr(ADDR_CTRL, 8'h01);
        wait_sig(0, 20, "en_first_tick", t);
        check("en_first_tick_delay", t - c_cyc, 8);
        #1;
        t16_have = 0;
        for (int i = 0; i < 4; i++) t16_q.push_back(8);
        wait_sig(1, 120, "en_tx_tick", t);
        check("en_tx_resume", t - c_cyc, 88);
        wait_drain(50, "en_drain");

        // Divisor 0: tick16 every clock.
        bus_wr(ADDR_DIV_LO, 8'h00);
        bus_wr(ADDR_DIV_HI, 8'h00);
        wait_commit(20, "div0_commit");
        t16_have = 0;
        for (int i = 0; i < 10; i++) t16_q.push_back(1);
        wait_drain(40, "div0_drain");

        // DIV_HI write in the same cycle as a committing reload.
        @(negedge clk);
        bus_wr(ADDR_DIV_LO, 8'h05);
        b_cyc = cyc;
        bus_wr(ADDR_DIV_HI, 8'h00);
        bus_wr(ADDR_DIV_HI, 8'h01);
        check("hicoll_no_tick", int'(tick16), 0);
        bus_rd(ADDR_STATUS, d);
        check("hicoll_pending_kept", int'(d[1]), 1);
        wait_sig(0, 20, "hicoll_tick", t);
        check("hicoll_old_shadow", t - b_cyc, 7);
        @(negedge clk);
        bus_rd(ADDR_STATUS, d);
        check("hicoll_pending_clr", int'(d[1]), 0);
        wait_sig(0, 300, "hicoll_new_tick", t2);
        check("hicoll_new_div", t2 - b_cyc, 269);

        // Fractional divisor (ignored in the default build).
        bus_wr(ADDR_DIV_LO, 8'h03);
        bus_wr(ADDR_DIV_HI, 8'h00);
        wait_commit(300, "frac_commit");
        @(negedge clk);
        bus_wr(ADDR_CTRL, 8'h81);
        bus_rd(ADDR_CTRL, d);
        check("frac_ctrl_rd", int'(d), int'(CTRL_81_RD));
        wait_sig(0, 20, "frac_t0", t0);
        #1;
        t16_have = 0;
        for (int i = 0; i < 15; i++) t16_q.push_back(FRAC_ON ? ((i % 2 == 0) ? 5 : 4) : 4);
        tl = t0;
        for (int k = 0; k < 16; k++) wait_sig(0, 10, "frac_tick", tl);
        check("frac_16_ticks", tl - t0, FRAC_TOTAL);
        wait_drain(20, "frac_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
